// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution datapath.
package conv_pkg;

    localparam int PROD_W   = 14;
    localparam int KERNEL_N = 9;

    typedef enum logic [0:0] {IDLE, STREAM} ser_state_t;

    typedef logic signed [PROD_W-1:0] prod_t;

endpackage

// File: rtl/prod_serializer.sv
// Product serializer: captures a bank of NUM_PROD signed products in one
// handshake and streams them one per beat over valid/ready, with an internal
// index counter. Optional bank-sum accumulator is enabled by defining
// PROD_SERIALIZER_ACCUM_EN.
module prod_serializer
    import conv_pkg::*;
#(
    parameter  int WIDTH    = PROD_W,
    parameter  int NUM_PROD = KERNEL_N,
    localparam int IDX_W    = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
`ifdef PROD_SERIALIZER_ACCUM_EN
    ,
    localparam int SUM_W    = WIDTH + $clog2(NUM_PROD)
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PROD*WIDTH-1:0] prod_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic signed [WIDTH-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      out_last,
    output logic                      busy
`ifdef PROD_SERIALIZER_ACCUM_EN
    ,
    output logic signed [SUM_W-1:0]   sum_out,
    output logic                      sum_valid
`endif
);

    typedef logic signed [WIDTH-1:0] lane_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PROD - 1);

    ser_state_t       r_state;
    ser_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    lane_t            r_bank [NUM_PROD];

    logic w_last;
    logic w_beat;
    logic w_accept;

    // Handshake qualifiers; in_ready re-opens on the last beat so the next
    // bank can load without a bubble.
    assign w_last    = (r_state == STREAM) && (r_idx == LAST_IDX);
    assign w_beat    = out_valid && out_ready;
    assign in_ready  = (r_state == IDLE) || (w_beat && w_last);
    assign w_accept  = in_valid && in_ready;

    assign out_valid = (r_state == STREAM);
    assign out_last  = w_last;
    assign out_idx   = r_idx;
    assign out_data  = r_bank[r_idx];
    assign busy      = (r_state == STREAM);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: leave STREAM only when the last beat goes with no new bank.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = STREAM;
            STREAM:  if (w_beat && w_last && !in_valid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Index counter: restarts on bank accept and wraps after the last beat.
    always_ff @(posedge clk) begin
        if (rst)
            r_idx <= '0;
        else if (w_accept)
            r_idx <= '0;
        else if (w_beat)
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
    end

    // Bank capture; prod_in is only sampled on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_PROD; k++) r_bank[k] <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < NUM_PROD; k++) r_bank[k] <= prod_in[k*WIDTH +: WIDTH];
        end
    end

`ifdef PROD_SERIALIZER_ACCUM_EN
    logic signed [SUM_W-1:0] r_acc;
    logic signed [SUM_W-1:0] w_acc_add;

    // Signed size cast sign-extends the beat into the wider accumulator.
    assign w_acc_add = r_acc + SUM_W'(out_data);

    // Running sum: the final beat is folded in directly into sum_out so a
    // back-to-back bank can clear r_acc on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= w_beat && w_last;
            if (w_beat && w_last) sum_out <= w_acc_add;
            if (w_accept)         r_acc   <= '0;
            else if (w_beat)      r_acc   <= w_acc_add;
        end
    end
`endif

endmodule

// File: tb/tb_prod_serializer.sv
// Directed bench for prod_serializer: default 9x14 instance plus a 1x8
// instance for the single-product corner.
module tb_prod_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 9 x 14 instance
    logic [9*14-1:0]    p0;
    logic               iv0, or0;
    logic               ir0, ov0, last0, busy0;
    logic signed [13:0] d0;
    logic [3:0]         idx0;
`ifdef PROD_SERIALIZER_ACCUM_EN
    logic signed [17:0] sum0;
    logic               sv0;
`endif

    // 1 x 8 instance
    logic [7:0]         p1;
    logic               iv1, or1;
    logic               ir1, ov1, last1, busy1;
    logic signed [7:0]  d1;
    logic [0:0]         idx1;
`ifdef PROD_SERIALIZER_ACCUM_EN
    logic signed [7:0]  sum1;
    logic               sv1;
`endif

    prod_serializer #(.WIDTH(14), .NUM_PROD(9)) u0 (
        .clk(clk), .rst(rst), .prod_in(p0), .in_valid(iv0), .in_ready(ir0),
        .out_data(d0), .out_valid(ov0), .out_ready(or0), .out_idx(idx0),
        .out_last(last0), .busy(busy0)
`ifdef PROD_SERIALIZER_ACCUM_EN
        , .sum_out(sum0), .sum_valid(sv0)
`endif
    );

    prod_serializer #(.WIDTH(8), .NUM_PROD(1)) u1 (
        .clk(clk), .rst(rst), .prod_in(p1), .in_valid(iv1), .in_ready(ir1),
        .out_data(d1), .out_valid(ov1), .out_ready(or1), .out_idx(idx1),
        .out_last(last1), .busy(busy1)
`ifdef PROD_SERIALIZER_ACCUM_EN
        , .sum_out(sum1), .sum_valid(sv1)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int bank_a[9];
    int bank_s[9];
    int bank_b[9];
    int e, c;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_bank(input int v[9]);
        for (int k = 0; k < 9; k++) p0[k*14 +: 14] = 14'(v[k]);
    endtask

    // Present a bank for one cycle; on return the first beat is visible.
    task automatic load(input int v[9]);
        set_bank(v);
        iv0 = 1'b1;
        @(negedge clk);
        iv0 = 1'b0;
    endtask

    // Check a full 9-beat stream with out_ready high, then the idle return.
    task automatic stream_bank(input int v[9], input string tag);
        int sum;
        sum = 0;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("%s data%0d", tag, k), d0, v[k]);
            chk($sformatf("%s idx%0d", tag, k), idx0, k);
            chk($sformatf("%s last%0d", tag, k), last0, (k == 8) ? 1 : 0);
            chk($sformatf("%s in_ready%0d", tag, k), ir0, (k == 8) ? 1 : 0);
            sum += v[k];
            if (k == 2) p0 = '0;   // captured bank must not follow prod_in
            @(negedge clk);
        end
        chk({tag, " idle valid"}, ov0, 0);
        chk({tag, " idle busy"}, busy0, 0);
        chk({tag, " idle in_ready"}, ir0, 1);
`ifdef PROD_SERIALIZER_ACCUM_EN
        chk({tag, " sum_valid"}, sv0, 1);
        chk({tag, " sum_out"}, sum0, sum);
        @(negedge clk);
        chk({tag, " sum_valid drop"}, sv0, 0);
        chk({tag, " sum_out hold"}, sum0, sum);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bank_a = '{100, 200, 300, 400, 500, 600, 700, 800, 900};
        bank_s = '{-8192, 8191, -1, 0, 1, -100, 50, 8191, -8192};
        bank_b = '{1, 2, 3, 4, 5, 6, 7, 8, 9};

        rst = 1'b1; iv0 = 1'b0; or0 = 1'b1; p0 = '0;
        iv1 = 1'b0; or1 = 1'b1; p1 = '0;
        @(negedge clk);
        @(negedge clk);

        // reset state
        chk("rst valid", ov0, 0);
        chk("rst busy", busy0, 0);
        chk("rst idx", idx0, 0);
        chk("rst last", last0, 0);
        chk("rst data", d0, 0);
        chk("rst u1 valid", ov1, 0);
`ifdef PROD_SERIALIZER_ACCUM_EN
        chk("rst sum_valid", sv0, 0);
        chk("rst sum_out", sum0, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("idle in_ready", ir0, 1);

        // basic stream, first beat one cycle after accept
        load(bank_a);
        chk("basic busy", busy0, 1);
        chk("basic valid", ov0, 1);
        stream_bank(bank_a, "basic");

        // signed extremes pass through unchanged
        load(bank_s);
        stream_bank(bank_s, "signed");

        // out_ready pattern 1,0,0,1: data/idx hold while stalled
        load(bank_a);
        e = 0; c = 0;
        while (e < 9 && c < 60) begin
            chk($sformatf("stall data c%0d", c), d0, (e + 1) * 100);
            chk($sformatf("stall idx c%0d", c), idx0, e);
            chk($sformatf("stall valid c%0d", c), ov0, 1);
            or0 = ((c % 4) == 0) || ((c % 4) == 3);
            if (or0) e++;
            c++;
            @(negedge clk);
        end
        chk("stall beats", e, 9);
        chk("stall end valid", ov0, 0);
`ifdef PROD_SERIALIZER_ACCUM_EN
        chk("stall sum", sum0, 4500);
        chk("stall sum_valid", sv0, 1);
`endif
        or0 = 1'b1;
        @(negedge clk);

        // back-to-back bank during the last beat
        load(bank_a);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("b2b a data%0d", k), d0, bank_a[k]);
            chk($sformatf("b2b a idx%0d", k), idx0, k);
            if (k == 8) begin
                set_bank(bank_b);
                iv0 = 1'b1;
                chk("b2b in_ready", ir0, 1);
            end
            @(negedge clk);
        end
        iv0 = 1'b0;
        chk("b2b no bubble", ov0, 1);
`ifdef PROD_SERIALIZER_ACCUM_EN
        chk("b2b a sum", sum0, 4500);
        chk("b2b a sum_valid", sv0, 1);
`endif
        stream_bank(bank_b, "b2b b");

        // reset on idx 4
        load(bank_a);
        for (int k = 0; k < 4; k++) @(negedge clk);
        chk("abort idx", idx0, 4);
        chk("abort data", d0, 500);
        rst = 1'b1;
        @(negedge clk);
        chk("abort valid", ov0, 0);
        chk("abort busy", busy0, 0);
        chk("abort idx0", idx0, 0);
        chk("abort last", last0, 0);
`ifdef PROD_SERIALIZER_ACCUM_EN
        chk("abort sum_valid", sv0, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("abort stays idle", ov0, 0);
        load(bank_b);
        stream_bank(bank_b, "fresh");

        // single-product instance
        p1 = 8'hFB;   // -5
        iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0;
        chk("np1 data", d1, -5);
        chk("np1 last", last1, 1);
        chk("np1 idx", idx1, 0);
        chk("np1 valid", ov1, 1);
        chk("np1 in_ready", ir1, 1);
        @(negedge clk);
        chk("np1 idle", ov1, 0);
        chk("np1 busy", busy1, 0);
`ifdef PROD_SERIALIZER_ACCUM_EN
        chk("np1 sum_valid", sv1, 1);
        chk("np1 sum", sum1, -5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
